// File: rtl/conv1_pkg.sv
// conv1_pkg: shared constants and types for the layer-1 convolution scheduler.
//   CONV1_K        window edge (3x3)
//   CONV1_FILTERS  output channels per engine result
//   CONV1_LATENCY  engine latency, window valid -> result valid
//   pixel_t / win_t  pixel word and 3x3 window (index 3*r+c, row-major)
//   sched_state_t  frame scheduler states
package conv1_pkg;
  localparam int CONV1_K       = 3;
  localparam int CONV1_FILTERS = 32;
  localparam int CONV1_LATENCY = 10;

  typedef logic [31:0]  pixel_t;
  typedef pixel_t [0:8] win_t;

  typedef enum logic [2:0] {
    IDLE, FILL, SLIDE, DRAIN, DONE
  } sched_state_t;
endpackage

// File: rtl/conv1_win_buf.sv
// conv1_win_buf: 3x3 column-sliding window buffer.
// Pixels arrive column-major, rows 0..2 of one column. Rows 0 and 1 park in a
// staging pair; row 2 completes the column, shifts the window left one column
// and drops the new column in on the right.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pix_vld      pixel data valid this cycle
//   pix_row      row of that pixel within its column (0..2)
//   pix          pixel data
//   win_cap      this pixel completes a window: publish it on win_data
//   win_data     last completed window, index 3*r+c; holds between windows
module conv1_win_buf
  import conv1_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_vld,
  input  logic [1:0]              pix_row,
  input  logic [DATA_W-1:0]       pix,
  input  logic                    win_cap,
  output logic [0:8][DATA_W-1:0]  win_data
);
  logic [0:8][DATA_W-1:0] win_q, win_nxt;
  logic [0:1][DATA_W-1:0] stage;

  // shifted window with the completed column on the right
  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < CONV1_K; r++) begin
      for (int c = 0; c < CONV1_K - 1; c++)
        win_nxt[CONV1_K*r+c] = win_q[CONV1_K*r+c+1];
    end
    win_nxt[2] = stage[0];
    win_nxt[5] = stage[1];
    win_nxt[8] = pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      stage    <= '0;
      win_data <= '0;
    end else if (pix_vld) begin
      if (pix_row == 2'd2) begin
        win_q <= win_nxt;
        if (win_cap) win_data <= win_nxt;
      end else begin
        stage[pix_row[0]] <= pix;
      end
    end
  end
endmodule

// File: rtl/conv1_sched.sv
// conv1_sched: frame scheduler for the layer-1 convolution engine.
// Streams an IMG_H x IMG_W single-channel image out of a 1-read-port pixel
// memory, builds 3x3 windows for the engine, tags each returning result with
// its output (row, col), and pulses done once everything has drained.
// The external engine's active-low reset is expected to be ~rst so it is
// flushed together with this block.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a frame (IDLE only)
//   img_rd_en/addr/data      pixel memory read; data 1 cycle after en
//   win_data, win_valid      window to the engine (pulse, data held)
//   conv_valid, conv_out     engine result, in issue order
//   res_valid/data/row/col   registered, tagged result
//   busy, done, err          frame active, end-of-frame pulse, sticky error
// Build option: define CONV1_RELU_EN to zero negative result channels.
module conv1_sched
  import conv1_pkg::*;
#(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int DATA_W     = 32,
  parameter int FILTER_NUM = 32,
  parameter int ADDR_W     = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               img_rd_en,
  output logic [ADDR_W-1:0]                  img_rd_addr,
  input  logic [DATA_W-1:0]                  img_rd_data,
  output logic [0:8][DATA_W-1:0]             win_data,
  output logic                               win_valid,
  input  logic                               conv_valid,
  input  logic [FILTER_NUM-1:0][DATA_W-1:0]  conv_out,
  output logic                               res_valid,
  output logic [FILTER_NUM-1:0][DATA_W-1:0]  res_data,
  output logic [4:0]                         res_row,
  output logic [4:0]                         res_col,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);
  localparam int LAST_WROW = IMG_H - CONV1_K;  // last window row
  localparam int LAST_WCOL = IMG_W - CONV1_K;  // last window col
  localparam int LAST_COL  = IMG_W - 1;        // last image col

  sched_state_t state, state_nxt;
  logic [4:0]   win_row, rd_col, out_row, out_col;
  logic [1:0]   rd_r, row_q, row_d;
  logic [1:0]   vld_pipe, last_pipe;   // [0] read issued, [1] read data present
  logic [9:0]   outstanding;
  logic         issue, col_end, rd_last, drained, accept;
  logic [ADDR_W-1:0] addr_nxt;
  logic [FILTER_NUM-1:0][DATA_W-1:0] res_nxt;

  assign issue   = (state == FILL) || (state == SLIDE);
  assign col_end = rd_r == 2'(CONV1_K - 1);
  // third row of a column finishes a window, except for the first two FILL columns
  assign rd_last = col_end && ((state == SLIDE) || (rd_col == 5'(CONV1_K - 1)));
  assign addr_nxt = ADDR_W'((int'(win_row) + int'(rd_r)) * IMG_W + int'(rd_col));
  assign img_rd_en = vld_pipe[0];
  assign accept  = conv_valid && (outstanding != '0);
  // nothing left in the read pipe nor at the engine
  assign drained = (outstanding == '0) && (vld_pipe == '0) && !win_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FILL;
      FILL:  if (col_end && rd_col == 5'(CONV1_K - 1)) state_nxt = SLIDE;
      SLIDE: if (col_end && rd_col == 5'(LAST_COL))
               state_nxt = (win_row == 5'(LAST_WROW)) ? DRAIN : FILL;
      DRAIN: if (drained) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // read scan: column-major within the 3-row band at win_row
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      win_row <= '0;
      rd_col  <= '0;
      rd_r    <= '0;
    end else if (issue) begin
      if (col_end) begin
        rd_r <= '0;
        if (state == SLIDE && state_nxt == FILL) begin
          rd_col  <= '0;
          win_row <= win_row + 5'd1;
        end else begin
          rd_col <= rd_col + 5'd1;
        end
      end else begin
        rd_r <= rd_r + 2'd1;
      end
    end
  end

  // read issue and data-return pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      last_pipe   <= '0;
      row_q       <= '0;
      row_d       <= '0;
      img_rd_addr <= '0;
      win_valid   <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[0], issue};
      last_pipe <= {last_pipe[0], issue && rd_last};
      row_q     <= rd_r;
      row_d     <= row_q;
      if (issue) img_rd_addr <= addr_nxt;
      win_valid <= vld_pipe[1] && last_pipe[1];
    end
  end

  conv1_win_buf #(.DATA_W(DATA_W)) u_win_buf (
    .clk      (clk),
    .rst      (rst),
    .pix_vld  (vld_pipe[1]),
    .pix_row  (row_d),
    .pix      (img_rd_data),
    .win_cap  (last_pipe[1]),
    .win_data (win_data)
  );

  // windows in flight at the engine; a result with none in flight is an error
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (conv_valid && outstanding == '0) err <= 1'b1;
      case ({win_valid, accept})
        2'b10:   outstanding <= outstanding + 10'd1;
        2'b01:   outstanding <= outstanding - 10'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < FILTER_NUM; k++) begin
`ifdef CONV1_RELU_EN
      res_nxt[k] = conv_out[k][DATA_W-1] ? '0 : conv_out[k];
`else
      res_nxt[k] = conv_out[k];
`endif
    end
  end

  // results come back in issue order, so a raster counter gives the tag
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      res_valid <= accept;
      if (state == IDLE && start) begin
        out_row <= '0;
        out_col <= '0;
      end else if (accept) begin
        res_data <= res_nxt;
        res_row  <= out_row;
        res_col  <= out_col;
        if (out_col == 5'(LAST_WCOL)) begin
          out_col <= '0;
          out_row <= out_row + 5'd1;
        end else begin
          out_col <= out_col + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == FILL) || (state_nxt == SLIDE) || (state_nxt == DRAIN);
      done <= state_nxt == DONE;
    end
  end
endmodule

// File: tb/tb_conv1_sched.sv
// tb_conv1_sched: directed bench for conv1_sched with a word=address pixel
// memory and a 10-cycle stub engine returning a fixed channel pattern.
module tb_conv1_sched;
  logic clk = 1'b0;
  logic rst, start, inj, clr;
  logic img_rd_en;
  logic [9:0] img_rd_addr;
  logic [31:0] img_rd_data;
  logic [0:8][31:0] win_data;
  logic win_valid, conv_valid, res_valid, busy, done, err;
  logic [31:0][31:0] conv_out, res_data;
  logic [4:0] res_row, res_col;
  logic [9:0] dly;

  always #5 clk = ~clk;

  conv1_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr), .img_rd_data(img_rd_data),
    .win_data(win_data), .win_valid(win_valid),
    .conv_valid(conv_valid), .conv_out(conv_out),
    .res_valid(res_valid), .res_data(res_data), .res_row(res_row), .res_col(res_col),
    .busy(busy), .done(done), .err(err)
  );

  // pixel memory: word = address, 1-cycle read latency
  always @(posedge clk) begin
    if (img_rd_en) img_rd_data <= 32'(img_rd_addr);
    else           img_rd_data <= 32'hDEADBEEF;
  end

  // stub engine: 10-cycle delay line, flushed by rst
  always @(posedge clk) begin
    if (rst) dly <= '0;
    else     dly <= {dly[8:0], win_valid};
  end
  assign conv_valid = dly[9] | inj;

  function automatic logic [31:0] stub_out(int k);
    if (k == 3) return 32'hBF800000;
    if (k == 4) return 32'h3F800000;
    return 32'(k);
  endfunction

  function automatic logic [31:0] exp_res(int k);
`ifdef CONV1_RELU_EN
    if (k == 3) return 32'h0;
`endif
    return stub_out(k);
  endfunction

  function automatic int res_bad_cnt(logic [31:0][31:0] d);
    int b = 0;
    for (int k = 0; k < 32; k++) if (d[k] !== exp_res(k)) b++;
    return b;
  endfunction

  // monitor: sampled on the falling edge
  int cyc = 0, s = 0;
  int n_win, n_rd, n_res, n_done, tag_bad, data_bad, exp_r, exp_c;
  int last_r, last_c, last_res_cyc, done_cyc;
  logic [0:8][31:0] win_log [0:1023];
  int win_cyc [0:1023];
  logic [31:0][31:0] last_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr) begin
      n_win <= 0; n_rd <= 0; n_res <= 0; n_done <= 0;
      tag_bad <= 0; data_bad <= 0; exp_r <= 0; exp_c <= 0;
      last_r <= -1; last_c <= -1; last_res_cyc <= -1; done_cyc <= -1;
    end else begin
      if (win_valid && n_win < 1024) begin
        win_log[n_win] <= win_data;
        win_cyc[n_win] <= cyc - s;
      end
      if (win_valid) n_win <= n_win + 1;
      if (img_rd_en) n_rd <= n_rd + 1;
      if (res_valid) begin
        n_res <= n_res + 1;
        if (int'(res_row) != exp_r || int'(res_col) != exp_c) tag_bad <= tag_bad + 1;
        data_bad <= data_bad + res_bad_cnt(res_data);
        last_r <= int'(res_row);
        last_c <= int'(res_col);
        last_data <= res_data;
        last_res_cyc <= cyc - s;
        if (exp_c == 25) begin exp_c <= 0; exp_r <= exp_r + 1; end
        else exp_c <= exp_c + 1;
      end
      if (done) begin
        n_done <= n_done + 1;
        done_cyc <= cyc - s;
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int idx;
    int cyc;
    int w [9];
  } wvec_t;
  wvec_t tbl [7];

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_rd_en"}, img_rd_en, 0);
    check({tag, "_rd_addr"}, img_rd_addr, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_tag"}, {res_row, res_col}, 0);
    check({tag, "_res_data_zero"}, res_data == '0, 1);
    check({tag, "_win_data_zero"}, win_data == '0, 1);
  endtask

  task automatic begin_frame();
    clr = 1'b1; start = 1'b1;
    tick();
    s = cyc; start = 1'b0; clr = 1'b0;
  endtask

  initial begin
    // window index, cycle of win_valid after the start edge, expected pixels
    tbl[0].idx = 0;   tbl[0].cyc = 11;   tbl[0].w = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    tbl[1].idx = 1;   tbl[1].cyc = 14;   tbl[1].w = '{1, 2, 3, 29, 30, 31, 57, 58, 59};
    tbl[2].idx = 2;   tbl[2].cyc = 17;   tbl[2].w = '{2, 3, 4, 30, 31, 32, 58, 59, 60};
    tbl[3].idx = 25;  tbl[3].cyc = 86;   tbl[3].w = '{25, 26, 27, 53, 54, 55, 81, 82, 83};
    tbl[4].idx = 26;  tbl[4].cyc = 95;   tbl[4].w = '{28, 29, 30, 56, 57, 58, 84, 85, 86};
    tbl[5].idx = 27;  tbl[5].cyc = 98;   tbl[5].w = '{29, 30, 31, 57, 58, 59, 85, 86, 87};
    tbl[6].idx = 675; tbl[6].cyc = 2186; tbl[6].w = '{725, 726, 727, 753, 754, 755, 781, 782, 783};
    for (int k = 0; k < 32; k++) conv_out[k] = stub_out(k);

    rst = 1'b1; start = 1'b0; inj = 1'b0; clr = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0; clr = 1'b0;
    tick();

    // full frame, with a stray start pulse mid-frame
    begin_frame();
    for (int i = 0; i < 6000 && n_done == 0; i++) begin
      start = (i == 300);
      tick();
    end
    start = 1'b0;
    check("frame_done_seen", n_done, 1);
    repeat (5) tick();
    for (int t = 0; t < 7; t++) begin
      for (int j = 0; j < 9; j++)
        check($sformatf("win%0d[%0d]", tbl[t].idx, j), win_log[tbl[t].idx][j], 32'(tbl[t].w[j]));
      check($sformatf("win%0d_cycle", tbl[t].idx), win_cyc[tbl[t].idx], tbl[t].cyc);
    end
    check("win_count", n_win, 676);
    check("rd_count", n_rd, 2184);
    check("res_count", n_res, 676);
    check("res_tag_order_bad", tag_bad, 0);
    check("res_data_bad", data_bad, 0);
    check("last_res_tag", {last_r[7:0], last_c[7:0]}, {8'd25, 8'd25});
    check("done_count", n_done, 1);
    check("done_after_last_res", done_cyc - last_res_cyc, 1);
    check("done_cycle", done_cyc, 2198);
    check("busy_after", busy, 0);
    check("err_after_frame", err, 0);
    check("res3", last_data[3], exp_res(3));
    check("res4", last_data[4], 32'h3F800000);
    check("res0", last_data[0], 32'h0);
    check("res31", last_data[31], 32'd31);

    // reset mid-frame, then restart
    begin_frame();
    for (int i = 0; i < 3000 && n_win < 100; i++) tick();
    check("reach_win100", n_win >= 100, 1);
    rst = 1'b1; clr = 1'b1;
    tick();
    check_outputs_zero("midrst");
    rst = 1'b0; clr = 1'b0;
    repeat (40) tick();
    check("abandoned_done", n_done, 0);
    check("abandoned_res", n_res, 0);
    begin_frame();
    for (int i = 0; i < 50 && n_win == 0; i++) tick();
    for (int j = 0; j < 9; j++)
      check($sformatf("restart_win0[%0d]", j), win_log[0][j], 32'(tbl[0].w[j]));
    check("restart_win0_cycle", win_cyc[0], 11);
    check("restart_err", err, 0);
    for (int i = 0; i < 6000 && n_done == 0; i++) tick();
    check("restart_done", n_done, 1);
    check("restart_win_count", n_win, 676);
    check("restart_tag_bad", tag_bad, 0);

    // unexpected result while idle
    clr = 1'b1; tick(); clr = 1'b0;
    inj = 1'b1; tick(); inj = 1'b0;
    tick();
    check("inj_err_set", err, 1);
    check("inj_no_res", n_res, 0);
    repeat (20) tick();
    check("inj_err_sticky", err, 1);
    check("inj_busy", busy, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("inj_err_clear", err, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/conv1_sched.md
Name: conv1_sched

Overview:
- Frame-level scheduler for the layer-1 convolution engine (9-way round-robin bank of 32 filters; one 3x3 window per cycle max; results 10 cycles after window valid).
- Reads a single-channel IMG_H x IMG_W image from a 1-read-port pixel memory and assembles 3x3 windows with a column-sliding buffer.
- Issues windows to the engine, then tags each returning 32-channel result with its output (row, col).
- Signals frame done once the pipeline has fully drained.

Parameters:
- IMG_W, 28, input image width.
- IMG_H, 28, input image height.
- DATA_W, 32, pixel/result width (IEEE-754 single).
- FILTER_NUM, 32, output channels per result.
- ADDR_W, 10, pixel memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin frame; sampled only in IDLE.
- img_rd_en  out  1  pixel read strobe.
- img_rd_addr  out  ADDR_W  pixel address, row*IMG_W+col.
- img_rd_data  in  DATA_W  pixel data, valid exactly 1 cycle after img_rd_en.
- win_data  out  DATA_W x9  window, index 3*r+c (row-major); feeds the engine data input.
- win_valid  out  1  window valid; feeds the engine valid input.
- conv_valid  in  1  engine result valid.
- conv_out  in  DATA_W x FILTER_NUM  engine result.
- res_valid  out  1  tagged result valid.
- res_data  out  DATA_W x FILTER_NUM  result.
- res_row  out  5  output row, 0..IMG_H-3.
- res_col  out  5  output col, 0..IMG_W-3.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, all counters 0. Reset mid-frame abandons the frame with no done pulse. The top level drives the engine's active-low reset from ~rst, so the engine is flushed in the same cycle.
- FSM states: IDLE, FILL, SLIDE, DRAIN, DONE.
  - IDLE: start=1 moves to FILL and sets busy=1. Start in any other state is ignored.
  - FILL: 9 consecutive reads (3 columns x 3 rows, column-major) at window row R, cols 0..2.
  - SLIDE: 3 reads per new column c+2; the window buffer shifts left one column.
  - After the last column of a row, go to FILL for row R+1. After row IMG_H-3 completes, go to DRAIN.
  - DRAIN: wait until outstanding==0, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Reads are issued every cycle within FILL/SLIDE; there are no read bubbles across the FILL->SLIDE or row boundaries.
- win_valid is a one-cycle pulse in the cycle after the data of the window's last read is captured.
- Window timing:
  - First window: win_valid high 11 cycles after the start-sampling edge.
  - Windows within a row: exactly 3 cycles apart.
  - First window of each row: 9 cycles after the previous window.
- Frame totals: (IMG_H-2)*(IMG_W-2) windows. Read count is (IMG_H-2)*(9+3*(IMG_W-3)), which is 2184 at the defaults.
- win_data holds its value between pulses.
- Outstanding counter (10 bits):
  - +1 on win_valid, -1 on conv_valid.
  - Both in the same cycle: counter unchanged.
  - conv_valid while outstanding==0 sets err and does not decrement.
  - err clears only on rst.
- Result tagging: the engine returns results in order, so the output (row, col) counter advances on each conv_valid. It wraps col at IMG_W-3 and increments row.
- res_valid, res_data, res_row and res_col are registered: 1 cycle after conv_valid, with the tag of that result.

Optional Feature:
- CONV1_RELU_EN defined: res_data[k] = 0 when conv_out[k][31]=1, else conv_out[k]. This is applied per channel in the output register stage, with no added latency.
- Undefined: res_data = conv_out unmodified.

Decomposition:
- Package conv1_pkg holds:
  - constants CONV1_K=3, CONV1_FILTERS=32, CONV1_LATENCY=10;
  - typedef pixel_t (logic [31:0]);
  - typedef win_t (pixel_t [0:8]);
  - enum sched_state_t.
- One sub-module: conv1_win_buf. It holds the 3x3 shift buffer with load-column/shift controls and exposes win_data.

Test Plan:
- Memory word = its address; start. Checks: window 0 = {0,1,2,28,29,30,56,57,58}; window 1 = {1,2,3,29,30,31,57,58,59}; window 26 (row 1, col 0) = {28,29,30,56,57,58,84,85,86}.
- Full frame with a stub engine (win_valid delayed 10 cycles). Checks: 676 win_valid, 2184 img_rd_en, first win_valid at cycle 11, last res at (25,25), done exactly once 1 cycle after the last res_valid plus drain, busy low afterwards.
- Stub returns conv_out[k] = k. Checks: res tags in raster order (0,0),(0,1)..(0,25),(1,0); res_data unmodified.
- Assert rst at window 100, then start again. Checks: outputs 0 the cycle after rst; err=0; first new window equals window 0 data; no done pulse from the abandoned frame.
- start pulsed while busy has no effect on counts. conv_valid injected in IDLE sets err=1, which stays set until rst.
- With CONV1_RELU_EN, conv_out[3]=0xBF800000 and conv_out[4]=0x3F800000 give res_data[3]=0 and res_data[4]=0x3F800000. Without the macro, res_data[3]=0xBF800000.
